param_depth_engine: RTL and testbench

Parametrised successor to the single-pixel Mandelbrot escape-time engine. It accepts one pixel job (c, coordinates, per-job iteration limit) over a valid/ready handshake and iterates z <= z^2 + c at one iteration per clock. It returns the escape depth tagged with the pixel coordinates over a back-pressurable valid/ready output. It is the unit that multi-engine arrays instantiate N times behind a job dispatcher.

---
 rtl/mandel_pkg.sv | 16 +
 rtl/mandel_step.sv | 47 ++++
 rtl/param_depth_engine.sv | 144 ++++++++++++++
 tb/tb_param_depth_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot depth engine family.
// Imported by the step datapath and the engine top.
package mandel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } engine_state_t;

    // Escape radius squared (4.0) expressed in the Q.2*FRAC domain of a squared magnitude.
    function automatic logic [63:0] esc_threshold(input int frac);
        return 64'd4 << (2 * frac);
    endfunction

endpackage

// File: rtl/mandel_step.sv
// One combinational Mandelbrot step: z' = z^2 + c plus the |z|^2 > 4 escape test.
// Products are formed at full width so only the final DW-bit results truncate.
module mandel_step
    import mandel_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    input  logic signed [DW-1:0] re_c,
    input  logic signed [DW-1:0] im_c,
    output logic signed [DW-1:0] next_re,
    output logic signed [DW-1:0] next_im,
    output logic                 esc
);

    localparam logic [63:0]   THRESH_FULL = esc_threshold(FRAC);
    localparam logic [2*DW:0] THRESH      = THRESH_FULL[2*DW:0];

    logic signed [2*DW-1:0] re_x;
    logic signed [2*DW-1:0] im_x;
    logic signed [2*DW:0]   re_w;
    logic signed [2*DW:0]   im_w;
    logic signed [2*DW-1:0] re2;
    logic signed [2*DW-1:0] im2;
    logic signed [2*DW:0]   cross2;
    logic        [2*DW:0]   mag;

    assign re_x = {{DW{re[DW-1]}}, re};
    assign im_x = {{DW{im[DW-1]}}, im};
    assign re_w = {{(DW+1){re[DW-1]}}, re};
    assign im_w = {{(DW+1){im[DW-1]}}, im};

    assign re2    = re_x * re_x;
    assign im2    = im_x * im_x;
    // The doubled cross term needs one extra bit for the (-2^(DW-1))^2 corner.
    assign cross2 = (re_w * im_w) <<< 1;

    // Both squares are non-negative, so an unsigned sum one bit wider cannot overflow.
    assign mag = {1'b0, re2} + {1'b0, im2};
    assign esc = (mag > THRESH);

    assign next_re = DW'((re2 - im2) >>> FRAC) + re_c;
    assign next_im = DW'(cross2 >>> FRAC) + im_c;

endmodule

// File: rtl/param_depth_engine.sv
// Single-pixel escape-time engine: accepts one job, iterates one step per clock,
// and holds the tagged depth on a back-pressurable output until it is taken.
module param_depth_engine
    import mandel_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int IW   = 8,
    parameter int XW   = 10,
    parameter int YW   = 9
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XW-1:0]        in_x,
    input  logic [YW-1:0]        in_y,
    input  logic [IW-1:0]        in_max_iter,
    input  logic signed [DW-1:0] in_re_c,
    input  logic signed [DW-1:0] in_im_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XW-1:0]        out_x,
    output logic [YW-1:0]        out_y,
    output logic [IW-1:0]        out_depth,
    output logic                 out_escaped,
    output logic                 busy
);

    engine_state_t state, next_state;

    logic [XW-1:0]        job_x;
    logic [YW-1:0]        job_y;
    logic [IW-1:0]        job_max;
    logic signed [DW-1:0] job_re_c;
    logic signed [DW-1:0] job_im_c;
    logic signed [DW-1:0] z_re;
    logic signed [DW-1:0] z_im;
    logic [IW-1:0]        count;

    logic signed [DW-1:0] next_re;
    logic signed [DW-1:0] next_im;
    logic                 esc;

    logic accept;
    logic iter_stop;
    logic handshake;

    mandel_step #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_step (
        .re      (z_re),
        .im      (z_im),
        .re_c    (job_re_c),
        .im_c    (job_im_c),
        .next_re (next_re),
        .next_im (next_im),
        .esc     (esc)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        iter_stop  = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = ITER;
                end
            end
            ITER: begin
                if (esc || (count == job_max)) begin
                    iter_stop  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    handshake  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            job_x    <= '0;
            job_y    <= '0;
            job_max  <= '0;
            job_re_c <= '0;
            job_im_c <= '0;
            z_re     <= '0;
            z_im     <= '0;
            count    <= '0;
        end else if (accept) begin
            job_x    <= in_x;
            job_y    <= in_y;
            job_max  <= in_max_iter;
            job_re_c <= in_re_c;
            job_im_c <= in_im_c;
            z_re     <= '0;
            z_im     <= '0;
            count    <= '0;
        end else if ((state == ITER) && !iter_stop) begin
            z_re  <= next_re;
            z_im  <= next_im;
            count <= count + 1'b1;
        end
    end

    // Results are captured on leaving ITER; out_valid follows one cycle into DONE.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_depth   <= '0;
            out_escaped <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
        end else begin
            if (iter_stop) begin
                out_depth   <= esc ? count : job_max;
                out_escaped <= esc;
                out_x       <= job_x;
                out_y       <= job_y;
            end
            if (handshake)          out_valid <= 1'b0;
            else if (state == DONE) out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_param_depth_engine.sv
// Randomised bench for param_depth_engine at default parameters, checked against
// a plain-arithmetic escape-time model.
module tb_param_depth_engine;

    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int IW   = 8;
    localparam int XW   = 10;
    localparam int YW   = 9;

    logic                 sysclk;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [XW-1:0]        in_x;
    logic [YW-1:0]        in_y;
    logic [IW-1:0]        in_max_iter;
    logic signed [DW-1:0] in_re_c;
    logic signed [DW-1:0] in_im_c;
    logic                 out_valid;
    logic                 out_ready;
    logic [XW-1:0]        out_x;
    logic [YW-1:0]        out_y;
    logic [IW-1:0]        out_depth;
    logic                 out_escaped;
    logic                 busy;

    int compared   = 0;
    int mismatched = 0;

    param_depth_engine #(
        .DW(DW), .FRAC(FRAC), .IW(IW), .XW(XW), .YW(YW)
    ) dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_max_iter (in_max_iter),
        .in_re_c     (in_re_c),
        .in_im_c     (in_im_c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_depth   (out_depth),
        .out_escaped (out_escaped),
        .busy        (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check_output(input string tag, input longint observed, input longint expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference: iterate the escape-time recurrence directly in wide integers.
    task automatic model(input int mi, input int rec, input int imc,
                         output int depth, output int escaped);
        longint re = 0;
        longint im = 0;
        longint nre;
        longint nim;
        depth   = mi;
        escaped = 0;
        for (int k = 0; k <= mi; k++) begin
            if (re * re + im * im > (64'sd4 << (2 * FRAC))) begin
                depth   = k;
                escaped = 1;
                return;
            end
            if (k == mi) return;
            nre = ((re * re - im * im) >>> FRAC) + rec;
            nim = ((2 * re * im) >>> FRAC) + imc;
            re  = longint'(shortint'(nre));
            im  = longint'(shortint'(nim));
        end
    endtask

    task automatic apply_stimulus(input int jx, input int jy, input int mi,
                                  input int rec, input int imc, input int hold);
        int exp_depth;
        int exp_esc;
        int cycles;
        model(mi, rec, imc, exp_depth, exp_esc);

        @(negedge sysclk);
        in_valid    = 1'b1;
        in_x        = XW'(jx);
        in_y        = YW'(jy);
        in_max_iter = IW'(mi);
        in_re_c     = DW'(rec);
        in_im_c     = DW'(imc);
        cycles = 0;
        while (!in_ready && cycles < 1000) begin
            @(negedge sysclk);
            cycles++;
        end
        if (!in_ready) begin
            check_output("in_ready_wait", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge sysclk);
        #1;
        check_output("busy_after_accept", busy, 1);
        check_output("in_ready_after_accept", in_ready, 0);

        // Junk offered while busy must be ignored.
        cycles = 0;
        while (!out_valid && cycles < 600) begin
            in_valid    = 1'b1;
            in_x        = XW'($urandom);
            in_y        = YW'($urandom);
            in_max_iter = IW'($urandom);
            in_re_c     = DW'($urandom);
            in_im_c     = DW'($urandom);
            @(posedge sysclk);
            #1;
            cycles++;
        end
        if (!out_valid) begin
            check_output("out_valid_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        check_output("latency", cycles, exp_depth + 2);
        check_output("depth", out_depth, exp_depth);
        check_output("escaped", out_escaped, exp_esc);
        check_output("out_x", out_x, jx);
        check_output("out_y", out_y, jy);

        for (int h = 0; h < hold; h++) begin
            @(posedge sysclk);
            #1;
            check_output("hold_valid", out_valid, 1);
            check_output("hold_depth", out_depth, exp_depth);
            check_output("hold_x", out_x, jx);
            check_output("hold_in_ready", in_ready, 0);
        end

        out_ready = 1'b1;
        @(posedge sysclk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_output("valid_after_take", out_valid, 0);
        check_output("in_ready_after_take", in_ready, 1);
        check_output("depth_kept", out_depth, exp_depth);
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_y        = '0;
        in_max_iter = '0;
        in_re_c     = '0;
        in_im_c     = '0;
        out_ready   = 1'b0;

        repeat (3) @(negedge sysclk);
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_depth", out_depth, 0);
        check_output("reset_x", out_x, 0);
        check_output("reset_busy", busy, 0);
        reset_n = 1'b1;

        apply_stimulus(17, 33, 10, 0, 0, 0);
        apply_stimulus(1023, 511, 50, 16'sh0200, 0, 0);
        apply_stimulus(5, 6, 255, -512, 0, 0);
        apply_stimulus(100, 200, 30, 64, 96, 20);
        apply_stimulus(7, 8, 12, -100, 50, 0);
        apply_stimulus(9, 10, 0, 300, -300, 0);
        apply_stimulus(11, 12, 0, 0, 0, 1);

        // Reset asserted between edges in the middle of a long job.
        @(negedge sysclk);
        in_valid    = 1'b1;
        in_max_iter = 8'd200;
        in_re_c     = '0;
        in_im_c     = '0;
        @(posedge sysclk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge sysclk);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("midreset_out_valid", out_valid, 0);
        check_output("midreset_in_ready", in_ready, 1);
        check_output("midreset_busy", busy, 0);
        repeat (2) @(negedge sysclk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge sysclk);
            #1;
            check_output("no_stale_valid", out_valid, 0);
        end
        apply_stimulus(21, 22, 15, 80, -40, 0);

        for (int n = 0; n < 30; n++) begin
            apply_stimulus($urandom_range(0, 1023), $urandom_range(0, 511),
                           ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 40),
                           $urandom_range(0, 1024) - 512, $urandom_range(0, 1024) - 512,
                           $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
